md_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair in the EX stage. It accepts the decoded MD function code (none/mthi/mtlo/mult/div) plus sign selection and operands. It sequences a fixed-latency multiply or an iterative 32-step restoring divide, then commits the result to HI/LO. It raises busy/stall_req so the hazard logic freezes the front end while a result is pending.

---
 rtl/md_pkg.sv | 31 +++
 rtl/md_sequencer_if.sv | 32 +++
 rtl/md_div_core.sv | 63 ++++++
 rtl/md_sequencer.sv | 147 ++++++++++++++
 tb/tb_md_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared encodings and defaults for the EX-stage multiply/divide sequencer.
// Latency: n/a (types, constants and a magnitude helper only).
// Backpressure: n/a.
package md_pkg;

    // Decoded MD function codes as issued by the controller.
    typedef enum logic [2:0] {
        MD_NONE = 3'd0,
        MD_MTHI = 3'd1,
        MD_MTLO = 3'd2,
        MD_MUL  = 3'd3,
        MD_DIV  = 3'd4
    } md_func_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_e;

    localparam int MD_MUL_LATENCY = 5;
    localparam int MD_DIV_STEPS   = 32;

    // Two's-complement magnitude when signed; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude 2^31.
    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// Bundle of EX-stage request, hazard and HI/LO result signals for md_sequencer.
// Latency: n/a (wires only).
// Backpressure: busy/stall_req tell the pipeline to hold its request.
// Ports: master = pipeline side (drives request), slave = sequencer side.
interface md_sequencer_if;
    import md_pkg::*;

    logic        start_valid;
    logic [2:0]  md_func;
    logic        md_sign;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hi_rd;
    logic        lo_rd;
    logic        cancel;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_result;

    modport master (
        output start_valid, md_func, md_sign, op_a, op_b, hi_rd, lo_rd, cancel,
        input  busy, stall_req, hi, lo, md_result
    );

    modport slave (
        input  start_valid, md_func, md_sign, op_a, op_b, hi_rd, lo_rd, cancel,
        output busy, stall_req, hi, lo, md_result
    );

endinterface

// File: rtl/md_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per step.
// Latency: DIV_STEPS enabled steps after load; o_done marks the final step.
// Backpressure: none; steps only advance while i_step is high.
// Ports: clk/reset, i_load + magnitudes, i_step, o_done, o_quot, o_rem.
module md_div_core
    import md_pkg::*;
#(
    parameter int DIV_STEPS = MD_DIV_STEPS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    input  logic        i_step,
    output logic        o_done,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem
);
    localparam int CW = $clog2(DIV_STEPS + 1);

    logic [CW-1:0] r_cnt;
    logic [31:0]   r_quo;
    logic [31:0]   r_rem;
    logic [31:0]   r_div;

    logic [32:0]   w_rem_sh;
    logic          w_fits;
    logic [31:0]   w_sub;
    logic          w_active;

    // Shift the next dividend bit into the partial remainder. The shifted
    // value can reach 33 bits, but once the divisor fits the difference is
    // below the divisor, so a 32-bit subtract is exact.
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_fits   = (w_rem_sh >= {1'b0, r_div});
    assign w_sub    = w_rem_sh[31:0] - r_div;
    assign w_active = i_step && (r_cnt != '0);

    // Asserted during the last step: quotient/remainder are final next cycle.
    assign o_done = w_active && (r_cnt == CW'(1));
    assign o_quot = r_quo;
    assign o_rem  = r_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(DIV_STEPS);
            r_quo <= i_dividend;
            r_rem <= '0;
            r_div <= i_divisor;
        end else if (w_active) begin
            r_cnt <= r_cnt - CW'(1);
            r_rem <= w_fits ? w_sub : w_rem_sh[31:0];
            r_quo <= {r_quo[30:0], w_fits};
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// Owns HI/LO in EX: mthi/mtlo writes, fixed-latency multiply, 32-step divide.
// Latency: mthi/mtlo 1 edge; mult MUL_LATENCY busy cycles; div 33 (div-by-0: 1).
// Backpressure: busy/stall_req hold the front end; new requests are ignored while busy.
// Ports: clk, reset (sync, active-high), md (slave modport: request in, HI/LO/hazard out).
module md_sequencer
    import md_pkg::*;
#(
    parameter int MUL_LATENCY = MD_MUL_LATENCY,
    parameter int DIV_STEPS   = MD_DIV_STEPS
) (
    input  logic          clk,
    input  logic          reset,
    md_sequencer_if.slave md
);
    md_state_e   r_state;
    logic        r_busy;
    logic [3:0]  r_cnt;
    logic        r_sign;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_dz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_go;
    logic        w_div_load;
    logic        w_div_done;
    logic [31:0] w_div_q;
    logic [31:0] w_div_r;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [31:0] w_fix_q;
    logic [31:0] w_fix_r;

    assign w_go       = md.start_valid && !md.cancel && (r_state == IDLE);
    assign w_div_load = w_go && (md.md_func == MD_DIV) && (md.op_b != 32'd0);

    // Sign-extend only for signed ops; the low 64 bits of a 64x64 product
    // are then the correct signed or unsigned 32x32 result.
    assign w_a_ext = {{32{r_sign & r_a[31]}}, r_a};
    assign w_b_ext = {{32{r_sign & r_b[31]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Divide-by-zero bypasses the core and commits fixed values.
    assign w_fix_q = r_dz ? 32'hFFFF_FFFF :
                     (r_sign && (r_a[31] ^ r_b[31])) ? (~w_div_q + 32'd1) : w_div_q;
    assign w_fix_r = r_dz ? r_a :
                     (r_sign && r_a[31]) ? (~w_div_r + 32'd1) : w_div_r;

    md_div_core #(
        .DIV_STEPS (DIV_STEPS)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_div_load),
        .i_dividend (md_abs(md.op_a, md.md_sign)),
        .i_divisor  (md_abs(md.op_b, md.md_sign)),
        .i_step     (r_state == DIV),
        .o_done     (w_div_done),
        .o_quot     (w_div_q),
        .o_rem      (w_div_r)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        case (md.md_func)
                            MD_MTHI: r_hi <= md.op_a;
                            MD_MTLO: r_lo <= md.op_a;
                            MD_MUL: begin
                                r_sign  <= md.md_sign;
                                r_a     <= md.op_a;
                                r_b     <= md.op_b;
                                r_cnt   <= 4'(MUL_LATENCY - 1);
                                r_state <= MUL;
                                r_busy  <= 1'b1;
                            end
                            MD_DIV: begin
                                r_sign  <= md.md_sign;
                                r_a     <= md.op_a;
                                r_b     <= md.op_b;
                                r_dz    <= (md.op_b == 32'd0);
                                r_state <= (md.op_b == 32'd0) ? FIX : DIV;
                                r_busy  <= 1'b1;
                            end
                            default: ;  // none and unused codes
                        endcase
                    end
                end
                MUL: begin
                    if (md.cancel) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == 4'd0) begin
                        r_hi    <= w_prod[63:32];
                        r_lo    <= w_prod[31:0];
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DIV: begin
                    if (md.cancel) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_div_done) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (!md.cancel) begin
                        r_lo <= w_fix_q;
                        r_hi <= w_fix_r;
                    end
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign md.busy      = r_busy;
    assign md.hi        = r_hi;
    assign md.lo        = r_lo;
    assign md.stall_req = r_busy && (md.hi_rd || md.lo_rd ||
                                     (md.start_valid && (md.md_func != 3'd0)));
    assign md.md_result = md.hi_rd ? r_hi : (md.lo_rd ? r_lo : 32'd0);

endmodule

// File: tb/tb_md_sequencer.sv
// Randomized + directed scoreboard bench for md_sequencer.
// Latency: n/a.
// Backpressure: requests are held until the sequencer is idle.
module tb_md_sequencer;
    import md_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    md_sequencer_if u_if();

    md_sequencer #(
        .MUL_LATENCY (5),
        .DIV_STEPS   (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (u_if.slave)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: architectural result of one accepted request.
    task automatic model(input logic [2:0] f, input logic s, input logic [31:0] a,
                         input logic [31:0] b, output exp_t e, output bit has);
        logic [63:0] p;
        longint      q, r;
        has = 1'b1;
        e.len = 0;
        case (f)
            3'd1: m_hi = a;
            3'd2: m_lo = a;
            3'd3: begin
                if (s) p = 64'(longint'($signed(a)) * longint'($signed(b)));
                else   p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
                e.len = 5;
            end
            3'd4: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                    e.len = 1;
                end else begin
                    if (s) begin
                        q = longint'($signed(a)) / longint'($signed(b));
                        r = longint'($signed(a)) % longint'($signed(b));
                    end else begin
                        q = longint'({32'd0, a}) / longint'({32'd0, b});
                        r = longint'({32'd0, a}) % longint'({32'd0, b});
                    end
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                    e.len = 33;
                end
            end
            default: has = 1'b0;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
    endtask

    // Drive a request and hold it until the sequencer accepts it.
    task automatic present(input logic [2:0] f, input logic s, input logic [31:0] a,
                           input logic [31:0] b);
        int g = 0;
        u_if.start_valid = 1'b1;
        u_if.md_func     = f;
        u_if.md_sign     = s;
        u_if.op_a        = a;
        u_if.op_b        = b;
        @(negedge clk);
        while (u_if.busy) begin
            g++;
            if (g > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: busy still %b after %0d cycles", u_if.busy, g);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        u_if.start_valid = 1'b0;
        u_if.md_func     = 3'd0;
    endtask

    task automatic issue(input logic [2:0] f, input logic s, input logic [31:0] a,
                         input logic [31:0] b);
        exp_t e;
        bit   has;
        model(f, s, a, b, e, has);
        if (has) exp_q.push_back(e);
        present(f, s, a, b);
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (u_if.busy) begin
            g++;
            if (g > 200) begin
                checks++;
                errors++;
                $display("FAIL idle_timeout: busy still %b after %0d cycles", u_if.busy, g);
                break;
            end
            @(negedge clk);
        end
    endtask

    // Monitor: pops one expectation per commit (busy falling, or an accepted
    // mthi/mtlo becoming visible) and checks stall_req every cycle.
    bit mon_pend = 1'b0;
    bit mon_prev = 1'b0;
    int mon_bcnt = 0;

    task automatic pop_check(input string tag, input bit chk_len, input int len_act);
        exp_t e;
        logic [31:0] want_res;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected: hi=%h lo=%h with no expected entry", tag, u_if.hi, u_if.lo);
        end else begin
            e = exp_q.pop_front();
            check32({tag, "_hi"}, u_if.hi, e.hi);
            check32({tag, "_lo"}, u_if.lo, e.lo);
            want_res = u_if.hi_rd ? e.hi : (u_if.lo_rd ? e.lo : 32'd0);
            check32({tag, "_md_result"}, u_if.md_result, want_res);
            if (chk_len) check32({tag, "_busy_len"}, 32'(len_act), 32'(e.len));
        end
    endtask

    initial begin
        logic want_stall;
        forever begin
            @(negedge clk);
            want_stall = u_if.busy && (u_if.hi_rd || u_if.lo_rd ||
                         (u_if.start_valid && (u_if.md_func != 3'd0)));
            check32("stall_req", 32'(u_if.stall_req), 32'(want_stall));
            if (mon_pend) begin
                pop_check("mtx", 1'b0, 0);
                mon_pend = 1'b0;
            end
            if (u_if.busy) begin
                mon_bcnt++;
            end else if (mon_prev) begin
                pop_check("commit", 1'b1, mon_bcnt);
                mon_bcnt = 0;
            end
            mon_pend = u_if.start_valid && !u_if.cancel && !reset && !u_if.busy &&
                       ((u_if.md_func == 3'd1) || (u_if.md_func == 3'd2));
            mon_prev = u_if.busy;
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        exp_t e;
        logic [2:0]  f;
        logic [31:0] a, b;
        u_if.start_valid = 1'b0;
        u_if.md_func     = 3'd0;
        u_if.md_sign     = 1'b0;
        u_if.op_a        = '0;
        u_if.op_b        = '0;
        u_if.hi_rd       = 1'b0;
        u_if.lo_rd       = 1'b0;
        u_if.cancel      = 1'b0;
        reset            = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check32("reset_hi", u_if.hi, 32'd0);
        check32("reset_lo", u_if.lo, 32'd0);
        check32("reset_busy", 32'(u_if.busy), 32'd0);
        @(posedge clk);
        #1;

        // Multiply / divide corner values.
        issue(3'd3, 1'b1, 32'hFFFF_FFFE, 32'd3);
        issue(3'd3, 1'b0, 32'hFFFF_FFFE, 32'd3);
        issue(3'd4, 1'b1, 32'hFFFF_FFF9, 32'd2);
        issue(3'd4, 1'b0, 32'd100, 32'd7);
        issue(3'd4, 1'b1, 32'h0000_1234, 32'd0);
        issue(3'd4, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

        // mflo right behind a mult: stalls until commit, then sees new lo.
        issue(3'd3, 1'b0, 32'd7, 32'd9);
        u_if.lo_rd = 1'b1;
        wait_idle();
        @(posedge clk);
        #1;
        u_if.lo_rd = 1'b0;

        // mthi presented while busy: held off until after the commit.
        issue(3'd3, 1'b1, 32'd5, 32'hFFFF_FFFD);
        issue(3'd1, 1'b0, 32'hCAFE_F00D, 32'd0);

        // Cancel at divide cycle 10: HI/LO keep prior values.
        e.hi = m_hi;
        e.lo = m_lo;
        e.len = 10;
        exp_q.push_back(e);
        present(3'd4, 1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        u_if.cancel = 1'b1;
        @(posedge clk);
        #1;
        u_if.cancel = 1'b0;
        issue(3'd3, 1'b0, 32'd6, 32'd7);

        // Reset in the second multiply cycle.
        e.hi = 32'd0;
        e.lo = 32'd0;
        e.len = 2;
        exp_q.push_back(e);
        present(3'd3, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;

        // Back-to-back mthi/mtlo never stall.
        issue(3'd1, 1'b0, 32'hDEAD_BEEF, 32'd0);
        issue(3'd2, 1'b0, 32'h0000_0001, 32'd0);

        // Random traffic, including unused function codes.
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(1, 7));
            a = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 300));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2, 3:    b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            u_if.hi_rd = 1'($urandom_range(0, 1));
            u_if.lo_rd = 1'($urandom_range(0, 1));
            issue(f, 1'($urandom_range(0, 1)), a, b);
        end
        u_if.hi_rd = 1'b0;
        u_if.lo_rd = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check32("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
